add16_sequencer: RTL and testbench

ADD16_SEQUENCER -- requirements
Module: add16_sequencer

---
 rtl/add16_sequencer_pkg.sv | 12 +
 rtl/rr_arb2.sv | 17 +
 rtl/add16_sequencer.sv | 137 +++++++++++++
 tb/tb_add16_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/add16_sequencer_pkg.sv
// Shared types and widths for the two-beat 16-bit add/sub sequencer.
package add16_sequencer_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on a tie when rr_en, otherwise requester 0 wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            // last == 1 means requester 1 won previously, so requester 0 goes next
            grant = (rr_en && !last) ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end
endmodule

// File: rtl/add16_sequencer.sv
// Arbitrates two requesters and runs each 16-bit add/sub as two passes
// through an external 8-bit adder (low byte, then high byte with carry).
module add16_sequencer
    import add16_sequencer_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req0_sub,
    input  logic        req1_sub,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_ci,
    input  logic [7:0]  add_sum,
    input  logic        add_co,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [15:0] resp_sum,
    output logic        resp_cout
);
    state_t              r_state;
    logic [WORD_W-1:0]   r_a;
    logic [WORD_W-1:0]   r_b;
    logic                r_sub;
    logic                r_id;
    logic                r_carry;
    logic                r_last;
    logic                r_resp_valid;
    logic                r_resp_id;
    logic [WORD_W-1:0]   r_sum;
    logic                r_cout;
    logic [1:0]          w_grant;
    logic                w_idle;
    logic                w_accept;

    rr_arb2 u_arb (
        .req   ({req1_valid, req0_valid}),
        .last  (r_last),
        .rr_en (RR_EN),
        .grant (w_grant)
    );

    assign w_idle     = (r_state == IDLE);
    assign w_accept   = w_idle && (w_grant != 2'b00);
    // rst_n gating keeps ready low during reset even though the state is already IDLE
    assign req0_ready = w_idle && rst_n && w_grant[0];
    assign req1_ready = w_idle && rst_n && w_grant[1];

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_sum   = r_sum;
    assign resp_cout  = r_cout;

    // Operand capture; subtraction is folded into ~b with carry-in 1
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a   <= w_grant[1] ? req1_a : req0_a;
            r_b   <= w_grant[1] ? (req1_sub ? ~req1_b : req1_b)
                                : (req0_sub ? ~req0_b : req0_b);
            r_sub <= w_grant[1] ? req1_sub : req0_sub;
            r_id  <= w_grant[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_carry      <= 1'b0;
            r_last       <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_sum        <= '0;
            r_cout       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_last  <= w_grant[1];
                        r_state <= LO;
                    end
                end
                LO: begin
                    r_sum[BYTE_W-1:0] <= add_sum;
                    r_carry           <= add_co;
                    r_state           <= HI;
                end
                HI: begin
                    r_sum[WORD_W-1:BYTE_W] <= add_sum;
                    r_cout                 <= add_co;
                    r_resp_id              <= r_id;
                    r_resp_valid           <= 1'b1;
                    r_state                <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
        case (r_state)
            LO: begin
                add_a  = r_a[BYTE_W-1:0];
                add_b  = r_b[BYTE_W-1:0];
                add_ci = r_sub;
            end
            HI: begin
                add_a  = r_a[WORD_W-1:BYTE_W];
                add_b  = r_b[WORD_W-1:BYTE_W];
                add_ci = r_carry;
            end
            default: begin
                add_a  = '0;
                add_b  = '0;
                add_ci = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_add16_sequencer.sv
// Directed bench: one round-robin and one fixed-priority instance share the
// request stimulus, each driving its own behavioural 8-bit adder.
module tb_add16_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_sub, req1_sub;
    logic        resp_ready;

    logic        a_req0_ready, a_req1_ready, a_add_ci, a_add_co, a_resp_valid, a_resp_id, a_resp_cout;
    logic [7:0]  a_add_a, a_add_b, a_add_sum;
    logic [15:0] a_resp_sum;
    logic        f_req0_ready, f_req1_ready, f_add_ci, f_add_co, f_resp_valid, f_resp_id, f_resp_cout;
    logic [7:0]  f_add_a, f_add_b, f_add_sum;
    logic [15:0] f_resp_sum;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign {a_add_co, a_add_sum} = {1'b0, a_add_a} + {1'b0, a_add_b} + {8'b0, a_add_ci};
    assign {f_add_co, f_add_sum} = {1'b0, f_add_a} + {1'b0, f_add_b} + {8'b0, f_add_ci};

    add16_sequencer #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(a_req0_ready), .req1_ready(a_req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_sub(req0_sub), .req1_sub(req1_sub),
        .add_a(a_add_a), .add_b(a_add_b), .add_ci(a_add_ci),
        .add_sum(a_add_sum), .add_co(a_add_co),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_id(a_resp_id),
        .resp_sum(a_resp_sum), .resp_cout(a_resp_cout)
    );

    add16_sequencer #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(f_req0_ready), .req1_ready(f_req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_sub(req0_sub), .req1_sub(req1_sub),
        .add_a(f_add_a), .add_b(f_add_b), .add_ci(f_add_ci),
        .add_sum(f_add_sum), .add_co(f_add_co),
        .resp_valid(f_resp_valid), .resp_ready(resp_ready), .resp_id(f_resp_id),
        .resp_sum(f_resp_sum), .resp_cout(f_resp_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1 with the DUT in IDLE and resp_ready high
    task automatic op(input string tag, input logic id, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic [15:0] es, input logic ec);
        logic [15:0] bx;
        bx = sub ? ~b : b;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
        end
        #1;
        chk({tag, ".ready"}, {a_req1_ready, a_req0_ready}, id ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk({tag, ".lo_ready"}, {a_req1_ready, a_req0_ready}, 2'b00);
        chk({tag, ".lo_add"}, {a_add_a, a_add_b, a_add_ci}, {a[7:0], bx[7:0], sub});
        chk({tag, ".lo_valid"}, a_resp_valid, 1'b0);
        @(posedge clk); #1;
        chk({tag, ".hi_add_a"}, a_add_a, a[15:8]);
        chk({tag, ".hi_add_b"}, a_add_b, bx[15:8]);
        chk({tag, ".hi_valid"}, a_resp_valid, 1'b0);
        @(posedge clk); #1;
        chk({tag, ".resp_valid"}, a_resp_valid, 1'b1);
        chk({tag, ".resp_sum"}, a_resp_sum, es);
        chk({tag, ".resp_cout"}, a_resp_cout, ec);
        chk({tag, ".resp_id"}, a_resp_id, id);
        chk({tag, ".resp_add_idle"}, {a_add_a, a_add_b, a_add_ci}, 17'h0);
        @(posedge clk); #1;
        chk({tag, ".done"}, a_resp_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_sub = 1'b0; req1_sub = 1'b0;
        #1;
        chk("rst.resp", {a_resp_valid, a_resp_sum, a_resp_cout, a_resp_id}, 19'h0);
        chk("rst.add", {a_add_a, a_add_b, a_add_ci}, 17'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        op("add_carry_lo", 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        op("add_wrap", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        op("sub_noborrow", 1'b0, 16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1);
        op("sub_borrow", 1'b0, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0);

        // Backpressure: hold the response while another request waits
        resp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h1234; req1_b = 16'h4321; req1_sub = 1'b0;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h0000; req0_b = 16'h0000; req0_sub = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp.valid", a_resp_valid, 1'b1);
        chk("bp.sum", a_resp_sum, 16'h5555);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.hold", {a_resp_valid, a_resp_id, a_resp_sum}, {1'b1, 1'b1, 16'h5555});
            chk("bp.nogrant", {a_req1_ready, a_req0_ready}, 2'b00);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.released", a_resp_valid, 1'b0);
        chk("bp.waiter_ready", a_req0_ready, 1'b1);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp.withdrawn_idle", {a_add_a, a_add_b, a_add_ci}, 17'h0);
        @(posedge clk); #1;
        chk("bp.withdrawn_noresp", a_resp_valid, 1'b0);

        // Reset pulse while in HI
        req0_valid = 1'b1; req0_a = 16'h12FF; req0_b = 16'h0001; req0_sub = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst.hi", {a_add_a, a_add_ci}, {8'h12, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("midrst.add_zero", {a_add_a, a_add_b, a_add_ci}, 17'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("midrst.noresp", a_resp_valid, 1'b0);
        end
        op("after_rst", 1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

        // Arbitration with both requesters held from reset
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_sub = 1'b0; req1_sub = 1'b0;
        #1;
        chk("arb.rst_ready_rr", {a_req1_ready, a_req0_ready}, 2'b00);
        chk("arb.rst_ready_fp", {f_req1_ready, f_req0_ready}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("arb.rr_grant", {a_req1_ready, a_req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("arb.fp_grant", {f_req1_ready, f_req0_ready}, 2'b01);
            repeat (4) @(posedge clk);
        end
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
